param_stack_machine: RTL

PARAM_STACK_MACHINE -- requirements
Module: param_stack_machine

---
 rtl/param_stack_machine.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/param_stack_machine.sv
// Small stack machine: fetches one instruction per FETCH/EXEC pair from an
// external program store addressed by pc, and executes it on an internal stack.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   start, prog_len    run request and instruction count (sampled on accepted start)
//   instr              {opcode[2:0], imm[IMM_W-1:0]}, valid in the same cycle as pc
//   pc                 instruction address
//   d_valid, out_data  one-cycle strobe and value of an ADD/SUB/MUL result
//   depth_cnt          stack occupancy
//   busy, fin          running / run complete (sticky)
//   err_code           sticky: 0 none, 1 underflow, 2 overflow, 3 illegal opcode
module param_stack_machine #(
    parameter int unsigned DATA_W = 20,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned IMM_W  = 10,
    parameter int unsigned PC_W   = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [PC_W-1:0]            prog_len,
    input  logic [3+IMM_W-1:0]         instr,
    output logic [PC_W-1:0]            pc,
    output logic                       d_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] depth_cnt,
    output logic                       busy,
    output logic                       fin,
    output logic [2:0]                 err_code
);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam int unsigned INSTR_W = 3 + IMM_W;

    localparam logic [2:0] OP_PUSH = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_DUP  = 3'd4;
    localparam logic [2:0] OP_DROP = 3'd5;
    localparam logic [2:0] OP_SWAP = 3'd6;

    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_UNF  = 3'd1;
    localparam logic [2:0] ERR_OVF  = 3'd2;
    localparam logic [2:0] ERR_ILL  = 3'd3;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE, S_ERR} state_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     len_q, len_d, pc_d;
    logic [2:0]          op_q, op_d;
    logic [IMM_W-1:0]    imm_q, imm_d;
    logic [CNT_W-1:0]    depth_d;
    logic                d_valid_d, busy_d, fin_d;
    logic [DATA_W-1:0]   out_d;
    logic [2:0]          err_d;

    logic [DATA_W-1:0]   stk [DEPTH];

    logic [2:0]          op_in;
    logic [IMM_W-1:0]    imm_in;
    logic [IDX_W-1:0]    top_idx, nxt_idx, push_idx;
    logic [DATA_W-1:0]   top_v, nxt_v, res, imm_ext;
    logic [2:0]          err_det;
    logic [PC_W:0]       pc_inc;
    logic                wr0_en, wr1_en;
    logic [IDX_W-1:0]    wr0_idx, wr1_idx;
    logic [DATA_W-1:0]   wr0_data, wr1_data;

    assign op_in    = instr[INSTR_W-1 -: 3];
    assign imm_in   = instr[IMM_W-1:0];
    assign top_idx  = IDX_W'(depth_cnt - CNT_W'(1));
    assign nxt_idx  = IDX_W'(depth_cnt - CNT_W'(2));
    assign push_idx = IDX_W'(depth_cnt);
    assign imm_ext  = DATA_W'($signed(imm_q));
    assign pc_inc   = (PC_W+1)'(pc) + (PC_W+1)'(1);

    // Stack reads are gated by occupancy so stale entries never leak out.
    assign top_v = (depth_cnt >= CNT_W'(1)) ? stk[top_idx] : '0;
    assign nxt_v = (depth_cnt >= CNT_W'(2)) ? stk[nxt_idx] : '0;

    // Result of the incoming arithmetic op, computed in FETCH so it is on out_data during EXEC.
    always_comb begin
        res = '0;
        case (op_in)
            OP_ADD:  res = top_v + nxt_v;
            OP_SUB:  res = top_v - nxt_v;
            default: res = top_v * nxt_v;
        endcase
    end

    // Error decode of the incoming instruction against current occupancy.
    always_comb begin
        err_det = ERR_NONE;
        case (op_in)
            OP_PUSH: if (depth_cnt == CNT_W'(DEPTH)) err_det = ERR_OVF;
            OP_ADD, OP_SUB, OP_MUL, OP_SWAP:
                     if (depth_cnt < CNT_W'(2)) err_det = ERR_UNF;
            OP_DUP:  if (depth_cnt < CNT_W'(1)) err_det = ERR_UNF;
                     else if (depth_cnt == CNT_W'(DEPTH)) err_det = ERR_OVF;
            OP_DROP: if (depth_cnt < CNT_W'(1)) err_det = ERR_UNF;
            default: err_det = ERR_ILL;
        endcase
    end

    // Next-state, datapath and stack-write control.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc;
        len_d     = len_q;
        op_d      = op_q;
        imm_d     = imm_q;
        depth_d   = depth_cnt;
        d_valid_d = 1'b0;
        out_d     = '0;
        err_d     = err_code;
        wr0_en    = 1'b0;
        wr0_idx   = push_idx;
        wr0_data  = '0;
        wr1_en    = 1'b0;
        wr1_idx   = nxt_idx;
        wr1_data  = '0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    len_d   = prog_len;
                    pc_d    = '0;
                    err_d   = ERR_NONE;
                    state_d = (prog_len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                op_d    = op_in;
                imm_d   = imm_in;
                err_d   = err_det;
                state_d = S_EXEC;
                if (err_det == ERR_NONE &&
                    (op_in == OP_ADD || op_in == OP_SUB || op_in == OP_MUL)) begin
                    d_valid_d = 1'b1;
                    out_d     = res;
                end
            end
            S_EXEC: begin
                if (err_code != ERR_NONE) begin
                    state_d = S_ERR;
                end else begin
                    case (op_q)
                        OP_PUSH: begin
                            wr0_en   = 1'b1;
                            wr0_data = imm_ext;
                            depth_d  = depth_cnt + CNT_W'(1);
                        end
                        OP_ADD, OP_SUB, OP_MUL: begin
                            wr0_en   = 1'b1;
                            wr0_idx  = nxt_idx;
                            wr0_data = out_data;
                            depth_d  = depth_cnt - CNT_W'(1);
                        end
                        OP_DUP: begin
                            wr0_en   = 1'b1;
                            wr0_data = top_v;
                            depth_d  = depth_cnt + CNT_W'(1);
                        end
                        OP_DROP: depth_d = depth_cnt - CNT_W'(1);
                        default: begin
                            wr0_en   = 1'b1;
                            wr0_idx  = top_idx;
                            wr0_data = nxt_v;
                            wr1_en   = 1'b1;
                            wr1_data = top_v;
                        end
                    endcase
                    // pc stays on the last instruction when the run completes.
                    if (pc_inc < (PC_W+1)'(len_q)) begin
                        pc_d    = pc + PC_W'(1);
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_FETCH) || (state_d == S_EXEC);
        fin_d  = (state_d == S_DONE)  || (state_d == S_ERR);
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc        <= '0;
            len_q     <= '0;
            op_q      <= '0;
            imm_q     <= '0;
            depth_cnt <= '0;
            d_valid   <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            fin       <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            state_q   <= state_d;
            pc        <= pc_d;
            len_q     <= len_d;
            op_q      <= op_d;
            imm_q     <= imm_d;
            depth_cnt <= depth_d;
            d_valid   <= d_valid_d;
            out_data  <= out_d;
            busy      <= busy_d;
            fin       <= fin_d;
            err_code  <= err_d;
        end
    end

    // Stack storage; no reset, writes only happen in EXEC so reset aborts cleanly.
    always_ff @(posedge clk) begin
        if (wr0_en) stk[wr0_idx] <= wr0_data;
        if (wr1_en) stk[wr1_idx] <= wr1_data;
    end
endmodule
